ps2_led_cmd_ctrl: RTL
=====================

Name: ps2_led_cmd_ctrl

Overview:
Host-to-keyboard command sequencer that drives the keyboard's Scroll/Num/Caps LEDs. It sits between the keypad logic, a PS/2 byte transmitter and the PS/2 byte receiver. It issues the Set-LEDs command 0xED, waits for the 0xFA ACK, sends the LED argument byte, then waits for a second ACK. Requests that arrive mid-transaction are latched and serviced once the current transaction ends.

Parameters:
TIMEOUT_CYC, 2000000, CLK cycles allowed per ACK wait (20 ms at 100 MHz); counter width $clog2(TIMEOUT_CYC+1)
MAX_RETRY, 3, resend attempts allowed per byte (used only with PS2_LED_RETRY_EN)

Ports:
CLK  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
iLED_req  in  1  one-cycle request to apply iLED
iLED  in  3  {Caps, Num, Scroll}; sampled when iLED_req=1
oLED  out  3  LED state last acknowledged by the keyboard
oBusy  out  1  high from request accept until DONE/ERR exit
oDone  out  1  one-cycle pulse on successful completion
oErr  out  1  one-cycle pulse on failure
tx_data  out  8  byte to transmit
tx_req  out  1  one-cycle launch pulse; issued only when tx_busy=0
tx_busy  in  1  transmitter occupied
tx_done  in  1  one-cycle pulse, frame sent
rx_data  in  8  received byte
rx_valid  in  1  one-cycle pulse, rx_data valid

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high, named reset.
- Reset values: oLED=3'b000, oBusy=0, oDone=0, oErr=0, tx_req=0, tx_data=8'h00, pending=0, FSM in IDLE. Reset mid-transaction aborts with no further pulses. tx_req is deasserted in the same cycle reset is sampled.
- States: IDLE, SEND_CMD, WAIT_CMD_TX, WAIT_ACK1, SEND_ARG, WAIT_ARG_TX, WAIT_ACK2, DONE, ERR.
- IDLE: on iLED_req, latch iLED into cur and go to SEND_CMD; oBusy=1 from the next cycle.
- SEND_CMD: when tx_busy=0, drive tx_data=8'hED with tx_req=1 for one cycle, then go to WAIT_CMD_TX.
- WAIT_CMD_TX: on tx_done, clear the timer and go to WAIT_ACK1. rx_valid is ignored in this state.
- WAIT_ACK1: the timer increments each cycle.
  - rx 0xFA: go to SEND_ARG.
  - rx 0xFE: resend (see Optional Feature).
  - Any other rx byte: ignored (stray scancode); the timer keeps running.
  - Timer reaching TIMEOUT_CYC: go to ERR.
- SEND_ARG: issue tx_data={5'b0,cur}; the keyboard bit order is bit2=Caps, bit1=Num, bit0=Scroll. WAIT_ARG_TX and WAIT_ACK2 mirror WAIT_CMD_TX and WAIT_ACK1.
- WAIT_ACK2 success: on rx 0xFA go to DONE; oLED<=cur in the same edge.
- DONE: oDone=1 for one cycle. ERR: oErr=1 for one cycle, oLED unchanged. Both exit to SEND_CMD if pending=1 (cur<=pend_val, pending<=0, oBusy stays 1), else to IDLE with oBusy=0.
- Request while oBusy=1: pend_val<=iLED, pending<=1. The last request wins; earlier pending values are overwritten.
- Request in the same cycle as the DONE/ERR exit is captured as pending and serviced next.
- Latency with an ideal transmitter (tx_done 1 cycle after tx_req, ACK 1 cycle after tx_done): request to oDone is 9 cycles.

Optional Feature:
PS2_LED_RETRY_EN.
- Defined:
  - rx 0xFE in WAIT_ACK1 or WAIT_ACK2 increments the per-byte retry counter and returns to SEND_CMD or SEND_ARG respectively, resending the same byte.
  - The retry counter clears on each 0xFA.
  - When the counter exceeds MAX_RETRY, go to ERR.
  - A timeout is also treated as a retry.
- Undefined: 0xFE or a timeout goes straight to ERR, and there is no retry counter logic.

Decomposition:
- Shared package ps2_pkg holds:
  - Byte constants: PS2_CMD_SET_LED=8'hED, PS2_ACK=8'hFA, PS2_RESEND=8'hFE.
  - The LED bit-index constants.
  - The FSM state encoding (4-bit).
- One sub-module, ps2_ack_timer: a loadable timeout counter with clear/enable inputs and an expired output, instantiated once.

Test Plan:
- Basic: iLED_req with iLED=3'b101; model ACKs both bytes. Expect tx bytes ED then 05, oLED=3'b101, a single oDone pulse, and oBusy low afterwards.
- Stray scancode: inject rx 0x1C in WAIT_ACK1 before 0xFA. The 0x1C is ignored, the transaction completes, and oLED is updated.
- Timeout (TIMEOUT_CYC=50): no ACK after ED. Expect oErr pulsed exactly at timer expiry, oLED unchanged, and a return to IDLE.
- Pending: request 3'b001, then requests 3'b010 and 3'b100 mid-transaction. After the first oDone, a second ED/04 sequence follows, ending with oLED=3'b100.
- Resend (macro defined, MAX_RETRY=3): answer the argument byte with FE twice then FA. Expect argument byte transmitted 3 times, then oDone. With four FEs, expect oErr. With the macro undefined, the first FE gives oErr.
- Reset asserted in WAIT_ARG_TX: next cycle all outputs are at reset values, and the pending request is discarded.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, LED bit positions and FSM encoding for the PS/2 LED command sequencer.
package ps2_pkg;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_ACK         = 8'hFA;
  localparam logic [7:0] PS2_RESEND      = 8'hFE;

  localparam int unsigned LED_SCROLL = 0;
  localparam int unsigned LED_NUM    = 1;
  localparam int unsigned LED_CAPS   = 2;

  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StSendCmd   = 4'd1,
    StWaitCmdTx = 4'd2,
    StWaitAck1  = 4'd3,
    StSendArg   = 4'd4,
    StWaitArgTx = 4'd5,
    StWaitAck2  = 4'd6,
    StDone      = 4'd7,
    StErr       = 4'd8
  } ps2_state_e;

  // leds is {Caps, Num, Scroll}; place each flag at the bit the keyboard expects.
  function automatic logic [7:0] led_arg_byte(input logic [2:0] leds);
    logic [7:0] b;
    b           = 8'h00;
    b[LED_CAPS]   = leds[2];
    b[LED_NUM]    = leds[1];
    b[LED_SCROLL] = leds[0];
    return b;
  endfunction

endpackage

// File: rtl/ps2_ack_timer.sv
// ACK-wait timeout counter: clr_i reloads zero, en_i counts, expired_o flags the last counted cycle.
module ps2_ack_timer #(
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted on the edge where the count reaches TIMEOUT_CYC.
  assign expired_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/ps2_led_cmd_ctrl.sv
// Set-LEDs (0xED + argument) command sequencer between keypad logic and PS/2 TX/RX.
// Define PS2_LED_RETRY_EN to resend a byte on 0xFE/timeout up to MAX_RETRY times.
module ps2_led_cmd_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       iLED_req,
  input  logic [2:0] iLED,
  output logic [2:0] oLED,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_busy,
  input  logic       tx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_valid
);

  ps2_state_e state_q, state_d;
  logic [2:0] cur_q, cur_d;
  logic [2:0] pend_val_q, pend_val_d;
  logic       pending_q, pending_d;
  logic [2:0] led_q, led_d;
  logic       busy_q, busy_d;
  logic       tx_req_q, tx_req_d;
  logic [7:0] tx_data_q, tx_data_d;

  logic timer_clr, timer_en, timer_expired;
  logic wait_ack, ack_evt, nack_evt, retry_ok;

  ps2_ack_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_ack_timer (
    .clk_i    (CLK),
    .rst_i    (reset),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expired_o(timer_expired)
  );

  assign wait_ack = (state_q == StWaitAck1) || (state_q == StWaitAck2);
  assign ack_evt  = wait_ack && rx_valid && (rx_data == PS2_ACK);
  // Stray scancodes fall through both terms and leave the timer running.
  assign nack_evt = wait_ack && !ack_evt &&
                    ((rx_valid && (rx_data == PS2_RESEND)) || timer_expired);

`ifdef PS2_LED_RETRY_EN
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
  logic [RetryW-1:0] retry_q, retry_d;

  assign retry_ok = (retry_q < RetryW'(MAX_RETRY));

  always_comb begin
    retry_d = retry_q;
    if (ack_evt || (state_q == StIdle) || (state_q == StDone) || (state_q == StErr)) begin
      retry_d = '0;
    end else if (nack_evt && retry_ok) begin
      retry_d = retry_q + RetryW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;
    led_d      = led_q;
    busy_d     = busy_q;
    tx_req_d   = 1'b0;
    tx_data_d  = tx_data_q;
    timer_clr  = 1'b0;
    timer_en   = 1'b0;

    // Last request while busy wins; DONE/ERR below consume it on exit.
    if (iLED_req && busy_q) begin
      pend_val_d = iLED;
      pending_d  = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (iLED_req) begin
          cur_d   = iLED;
          busy_d  = 1'b1;
          state_d = StSendCmd;
        end
      end
      StSendCmd: begin
        if (!tx_busy) begin
          tx_req_d  = 1'b1;
          tx_data_d = PS2_CMD_SET_LED;
          state_d   = StWaitCmdTx;
        end
      end
      StSendArg: begin
        if (!tx_busy) begin
          tx_req_d  = 1'b1;
          tx_data_d = led_arg_byte(cur_q);
          state_d   = StWaitArgTx;
        end
      end
      StWaitCmdTx, StWaitArgTx: begin
        if (tx_done) begin
          timer_clr = 1'b1;
          state_d   = (state_q == StWaitCmdTx) ? StWaitAck1 : StWaitAck2;
        end
      end
      StWaitAck1, StWaitAck2: begin
        timer_en = 1'b1;
        if (ack_evt) begin
          if (state_q == StWaitAck1) begin
            state_d = StSendArg;
          end else begin
            led_d   = cur_q;
            state_d = StDone;
          end
        end else if (nack_evt) begin
          if (!retry_ok) begin
            state_d = StErr;
          end else begin
            state_d = (state_q == StWaitAck1) ? StSendCmd : StSendArg;
          end
        end
      end
      StDone, StErr: begin
        if (iLED_req || pending_q) begin
          cur_d     = iLED_req ? iLED : pend_val_q;
          pending_d = 1'b0;
          state_d   = StSendCmd;
        end else begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= StIdle;
      cur_q      <= 3'b000;
      pend_val_q <= 3'b000;
      pending_q  <= 1'b0;
      led_q      <= 3'b000;
      busy_q     <= 1'b0;
      tx_req_q   <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      pend_val_q <= pend_val_d;
      pending_q  <= pending_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      tx_req_q   <= tx_req_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign oLED    = led_q;
  assign oBusy   = busy_q;
  assign oDone   = (state_q == StDone);
  assign oErr    = (state_q == StErr);
  assign tx_req  = tx_req_q;
  assign tx_data = tx_data_q;

endmodule
